// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder time-shared over WIDTH cycles, LSB first, with valid/ready in and out.
// Optional subtract mode is compiled in with `define SERIAL_ADD_SUB_EN (adds the 'sub' input).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry_q;
  logic             fa_b, fa_s, fa_c;
  logic             accept, last_bit, out_fire;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE, and the result is held until out_ready.
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  assign fa_b = b_sh[0] ^ sub_q;
`else
  assign fa_b = b_sh[0];
`endif

  full_adder u_fa (a_sh[0], fa_b, carry_q, fa_s, fa_c);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      carry   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh    <= a_in;
      b_sh    <= b_in;
      cnt_q   <= '0;
      sum     <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub;
      carry_q <= sub ? 1'b1 : c_in;
`else
      carry_q <= c_in;
`endif
    end else if (state_q == RUN) begin
      // Sum enters from the MSB so bit 0 lands at the LSB after WIDTH shifts.
      sum     <= {fa_s, sum[WIDTH-1:1]};
      carry_q <= fa_c;
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      if (last_bit) begin
        cnt_q <= '0;
        carry <= fa_c;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed table, hand sequences (backpressure, mid-run reset)
// and randomized operands compared against an arithmetic reference model.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in, b_in;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub_i;
`endif

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    int           hold;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on WIDTH+1 bits; subtract is a + ~b + 1.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int hold, output logic [W-1:0] rs, output logic rc);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 4 * W);
    chk("latency", 32'(lat), 32'(W));
    rs = sum; rc = carry;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'(rs));
      chk("bp_carry", 32'(carry), 32'(rc));
      in_valid = (i == 1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_sum_held", 32'(sum), 32'(rs));
  endtask

  vec_t vecs[$];
  logic [W-1:0] rs;
  logic         rc;
  logic [W:0]   exp_v;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub_i = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_carry", 32'(carry), 32'd0);

    vecs.push_back('{8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b1, 0, 8'h00, 1'b1});
    vecs.push_back('{8'h3C, 8'h0F, 1'b0, 5, 8'h4B, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1, 8'hFF, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b1, 2, 8'h04, 1'b0});
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].hold, rs, rc);
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_carry", i), 32'(rc), 32'(vecs[i].exp_carry));
    end

    // Reset while bit 3 is in flight: operation is dropped.
    @(negedge clk);
    a_in = 8'hF0; b_in = 8'h0F; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_carry", 32'(carry), 32'd0);
    repeat (W + 2) @(posedge clk);
    #1 chk("midrst_no_result", 32'(out_valid), 32'd0);
    do_op(8'h12, 8'h34, 1'b0, 0, rs, rc);
    chk("fresh_sum", 32'(rs), 32'h46);
    chk("fresh_carry", 32'(rc), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
    sub_i = 1'b1;
    do_op(8'h05, 8'h07, 1'b0, 0, rs, rc);
    chk("sub_5m7_sum", 32'(rs), 32'hFE);
    chk("sub_5m7_carry", 32'(rc), 32'd0);
    do_op(8'h07, 8'h05, 1'b1, 0, rs, rc);
    chk("sub_7m5_sum", 32'(rs), 32'h02);
    chk("sub_7m5_carry", 32'(rc), 32'd1);
    sub_i = 1'b0;
`endif

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic         rci, rsub;
      ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
      rsub = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      rsub = 1'($urandom);
      sub_i = rsub;
`endif
      exp_v = model(ra, rb, rci, rsub);
      do_op(ra, rb, rci, $urandom_range(0, 3), rs, rc);
      chk($sformatf("rand%0d_sum", n), 32'(rs), 32'(exp_v[W-1:0]));
      chk($sformatf("rand%0d_carry", n), 32'(rc), 32'(exp_v[W]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
